// File: rtl/ucdp_clk_div.sv
// ucdp_clk_div: programmable glitch-free even clock divider.
// clk_o is a registered 50%-duty clock with period 2*(ratio_q+1) clk_i cycles.
// A new ratio is captured into a pending register and only takes effect at the
// falling edge of clk_o, so no high or low phase is ever shortened.
// Optional feature: define UCDP_CLK_DIV_ACK_EN to add ratio_ack_o, a one-cycle
// pulse on the edge where the pending ratio is copied into the active ratio.
//
// Ratio handshake: ratio_vld_i is a one-cycle strobe with no back-pressure.
// Every strobe is accepted; ratio_i is stored on that edge (a later strobe
// overwrites an unapplied one) and busy_o stays high until it is applied.
module ucdp_clk_div #(
    parameter int unsigned RATIO_WIDTH = 4,
    parameter int unsigned RATIO_RST   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_an_i,
    input  logic                   en_i,
    input  logic [RATIO_WIDTH-1:0] ratio_i,
    input  logic                   ratio_vld_i,
    output logic                   busy_o,
    output logic                   tick_o,
    output logic                   clk_o
`ifdef UCDP_CLK_DIV_ACK_EN
    ,
    output logic                   ratio_ack_o
`endif
);

    // IDLE: clk_o parked low. RUN: dividing. STOP: final low phase after a
    // stop request, so the last low phase is as long as every other one.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [RATIO_WIDTH-1:0] pend_q, pend_d;
    logic                   busy_q, busy_d;
    logic                   clk_q, clk_d;
    logic                   tick_q, tick_d;
    logic                   cnt_last;
    logic                   apply;

    // Compare before increment, so an all-ones ratio never wraps the counter.
    assign cnt_last = (cnt_q == ratio_q);

    // Next-state, counter, ratio-apply and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        apply   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                apply = busy_q;
                if (en_i) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                    // Falling edge of clk_o is the period boundary.
                    if (clk_q) begin
                        apply = busy_q;
                        if (!en_i) begin
                            state_d = ST_STOP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                clk_d = 1'b0;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (apply) begin
            ratio_d = pend_q;
            busy_d  = 1'b0;
        end

        // A strobe coinciding with an apply stays pending for the next one.
        if (ratio_vld_i) begin
            pend_d = ratio_i;
            busy_d = 1'b1;
        end
    end

    assign tick_d = clk_d & ~clk_q;

    // State and datapath registers; async reset forces clk_o low at once.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ratio_q <= RATIO_WIDTH'(RATIO_RST);
            pend_q  <= RATIO_WIDTH'(RATIO_RST);
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

`ifdef UCDP_CLK_DIV_ACK_EN
    logic ack_q;

    // One-cycle acknowledge on the edge that loads the active ratio.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= apply;
        end
    end

    assign ratio_ack_o = ack_q;
`endif

    assign busy_o = busy_q;
    assign tick_o = tick_q;
    assign clk_o  = clk_q;

endmodule

// File: tb/tb_ucdp_clk_div.sv
// Bench for ucdp_clk_div: directed sequence with hand-computed per-cycle
// expectations of {ack, busy, tick, clk}, checked through a scoreboard queue.
module tb_ucdp_clk_div;

  localparam int W = 4;

  logic         clk_i;
  logic         rst_an_i;
  logic         en_i;
  logic [W-1:0] ratio_i;
  logic         ratio_vld_i;
  logic         busy_o;
  logic         tick_o;
  logic         clk_o;
  logic         ack_w;

  int checks;
  int failures;
  int cyc;

  // Entry: [7:4] care mask, [3:0] expected {ack, busy, tick, clk}.
  logic [7:0] exp_q[$];

`ifdef UCDP_CLK_DIV_ACK_EN
  localparam logic [3:0] CARE = 4'b1111;
`else
  localparam logic [3:0] CARE = 4'b0111;
`endif

  ucdp_clk_div #(
    .RATIO_WIDTH(W),
    .RATIO_RST(0)
  ) dut (
    .clk_i(clk_i),
    .rst_an_i(rst_an_i),
    .en_i(en_i),
    .ratio_i(ratio_i),
    .ratio_vld_i(ratio_vld_i),
    .busy_o(busy_o),
    .tick_o(tick_o),
    .clk_o(clk_o)
`ifdef UCDP_CLK_DIV_ACK_EN
    ,
    .ratio_ack_o(ack_w)
`endif
  );

`ifndef UCDP_CLK_DIV_ACK_EN
  assign ack_w = 1'b0;
`endif

  // Clock and cycle counter.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compare current outputs against the queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      logic [3:0] got;
      e   = exp_q.pop_front();
      got = {ack_w, busy_o, tick_o, clk_o};
      checks++;
      if (((got ^ e[3:0]) & e[7:4]) != 4'b0000) begin
        failures++;
        $display("FAIL outputs cyc=%0d ack/busy/tick/clk got=%b want=%b care=%b",
                 cyc, got, e[3:0], e[7:4]);
      end
    end
  end

  // Driver: queue expectation of the outputs visible now, then apply the
  // inputs for the next clk_i edge and advance one cycle.
  task automatic step(input logic en, input logic vld, input logic [W-1:0] r,
                      input logic e_clk, input logic e_tick, input logic e_busy,
                      input logic e_ack);
    exp_q.push_back({CARE, e_ack, e_busy, e_tick, e_clk});
    en_i        = en;
    ratio_vld_i = vld;
    ratio_i     = r;
    @(posedge clk_i);
    #1;
  endtask

  // A run of n cycles at one clk_o level; tick expected on the first high cycle.
  task automatic phase(input logic lvl, input int n, input logic en,
                       input logic busy, input logic ack_first);
    for (int i = 0; i < n; i++) begin
      step(en, 1'b0, '0, lvl, lvl && (i == 0), busy, (i == 0) ? ack_first : 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    rst_an_i    = 1'b0;
    en_i        = 1'b1;
    ratio_vld_i = 1'b0;
    ratio_i     = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state, then release with en_i=1 and RATIO_RST=0: 1 high / 1 low.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    rst_an_i = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    phase(1, 1, 1, 0, 0);
    phase(0, 1, 1, 0, 0);
    phase(1, 1, 1, 0, 0);
    phase(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    phase(0, 4, 0, 0, 0);

    // IDLE strobe ratio 3: busy one cycle, then 4 high / 4 low.
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    repeat (2) begin
      phase(1, 4, 1, 0, 0);
      phase(0, 4, 1, 0, 0);
    end

    // en_i=0 on the 2nd high cycle: high completes, low 4, then stays low.
    step(1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    phase(0, 8, 0, 0, 0);

    // Restart, stop again, and raise en_i inside the final low phase.
    step(1, 0, 0, 0, 0, 0, 0);
    phase(1, 3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    phase(1, 4, 1, 0, 0);
    phase(0, 4, 1, 0, 0);
    phase(1, 4, 0, 0, 0);
    phase(0, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Ratio 2 running; strobe 5 mid high phase keeps 3/3, then 6/6.
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    phase(1, 3, 1, 0, 0);
    phase(0, 3, 1, 0, 0);
    step(1, 1, 5, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    phase(0, 6, 1, 0, 1);
    phase(1, 6, 1, 0, 0);

    // Strobes 7 then 1 in one period: only ratio 1 (2/2) is applied.
    step(1, 1, 7, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    phase(0, 3, 1, 1, 0);
    phase(1, 6, 1, 1, 0);
    phase(0, 2, 1, 0, 1);
    phase(1, 2, 1, 0, 0);
    phase(0, 2, 1, 0, 0);

    // Strobe on the boundary edge: old pending (0) applied, new (2) stays pending.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 2, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1, 1, 0);

    // Ratio 2 applied; strobe max ratio 15: period 32, no counter wrap.
    step(1, 1, 15, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    phase(1, 3, 1, 1, 0);
    phase(0, 16, 1, 0, 1);
    phase(1, 16, 1, 0, 0);
    phase(0, 16, 1, 0, 0);

    // Reset mid high phase: clk_o low in the same cycle, ratio back to 0.
    phase(1, 5, 1, 0, 0);
    rst_an_i = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    rst_an_i = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    phase(1, 1, 1, 0, 0);
    phase(0, 1, 1, 0, 0);
    phase(1, 1, 1, 0, 0);
    phase(0, 1, 1, 0, 0);

    @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0 entries left", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
